// File: rtl/cipher_pkg.sv
// Shared types and constants for the cipher round sequencer.
package cipher_pkg;
  typedef enum logic [1:0] {IDLE, ROUND, DONE} round_state_t;
  localparam int         NUM_ROUNDS = 16;
  localparam logic [3:0] LAST_ROUND = 4'd15;
  localparam int         DATA_W     = 128;
endpackage

// File: rtl/cipher_round_ctrl.sv
// Round sequencer: accepts a block, runs it through the external round function
// for 16 cycles while stepping the round counter, then holds the result for handoff.
module cipher_round_ctrl
  import cipher_pkg::*;
#(
  parameter int DW = DATA_W
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_block,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_block,
  output logic          count_enable,
  input  logic [3:0]    round_count,
  input  logic          cnt_rollover,
  output logic [DW-1:0] rf_state,
  input  logic [DW-1:0] rf_result,
  output logic          busy,
  output logic          sync_err
);

  round_state_t  state, nstate;
  logic [DW-1:0] state_reg;
  logic          armed;
  logic          accept;

  // armed keeps in_ready low while reset is asserted and for the first cycle after
  assign accept    = (state == IDLE) && armed && in_valid;
  assign out_block = state_reg;
  assign rf_state  = state_reg;

  // State register and post-reset arming flag
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      armed <= 1'b0;
    end else begin
      state <= nstate;
      armed <= 1'b1;
    end
  end

  // Next-state and handshake/control outputs
  always_comb begin
    nstate       = state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    count_enable = 1'b0;
    busy         = 1'b0;
    case (state)
      IDLE: begin
        in_ready = armed;
        if (accept) nstate = ROUND;
      end
      ROUND: begin
        count_enable = 1'b1;
        busy         = 1'b1;
        if (round_count == LAST_ROUND) nstate = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  // Block state: load on accept, replace with round output each ROUND cycle, frozen otherwise
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)              state_reg <= '0;
    else if (accept)         state_reg <= in_block;
    else if (state == ROUND) state_reg <= rf_result;
  end

  // Sticky counter-desync flag: counter not at 0 on accept, or rollover out of step
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      sync_err <= 1'b0;
    else if (accept && round_count != 4'd0)
      sync_err <= 1'b1;
    else if (state == ROUND && cnt_rollover != (round_count == LAST_ROUND))
      sync_err <= 1'b1;
  end

endmodule
